ex_block: RTL and testbench
===========================

EX_BLOCK -- requirements
Module: ex_block

Interface
REQ-001 The block SHALL have clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 The block SHALL have reset, input, 1 bit: synchronous, active-low reset; 0 sampled at a rising edge resets the block.
REQ-003 The block SHALL have A and B, inputs, 8 bits each: register operands from the decode stage.
REQ-004 The block SHALL have imm, input, 8 bits: immediate operand.
REQ-005 The block SHALL have imm_sel, input, 1 bit: 1 replaces the forwarded B with imm as ALU operand 2.
REQ-006 The block SHALL have op_ex, input, 3 bits: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-007 The block SHALL have fwd_a and fwd_b, inputs, 2 bits each: 00 register, 01 ans_ex, 10 ans_dm, 11 treated as 00.
REQ-008 The block SHALL have ans_dm, input, 8 bits: memory-stage result for forwarding.
REQ-009 The block SHALL have valid_id, mem_rw_id, mem_en_id and mem_mux_sel_id, inputs, 1 bit each: instruction valid and memory controls from decode.
REQ-010 The block SHALL have ans_ex, output, 8 bits: registered result to the memory stage.
REQ-011 The block SHALL have DM_data, output, 8 bits: registered store data.
REQ-012 The block SHALL have mem_rw_ex, mem_en_ex and mem_mux_sel_dm, outputs, 1 bit each: registered memory controls.
REQ-013 The block SHALL have flag_ex, output, 4 bits: registered {Z,C,N,V}.
REQ-014 The block SHALL have stall, output, 1 bit: combinational; 1 means decode holds its outputs.

Function
REQ-015 The ALU SHALL take operand 1 as A after forwarding, and operand 2 as imm when imm_sel=1, otherwise B after forwarding.
REQ-016 Forwarding from ans_ex SHALL use the currently registered ans_ex value.
REQ-017 DM_data SHALL load B after forwarding, never imm.
REQ-018 ADD, SUB, AND, OR and XOR SHALL be 8-bit modulo operations.
REQ-019 SHL and SHR SHALL be logical shifts by operand2[2:0], with the shift amount 0 leaving the value unchanged.
REQ-020 MUL SHALL produce the low 8 bits of the unsigned 8x8 product.
REQ-021 Flag Z SHALL be 1 when the result equals 0.
REQ-022 Flag N SHALL equal result bit 7.
REQ-023 Flag C SHALL be the carry-out for ADD, the borrow (operand1 < operand2 unsigned) for SUB, and the last bit shifted out for shifts (0 for amount 0); it SHALL be 0 for logic ops and MUL.
REQ-024 Flag V SHALL be the signed overflow for ADD/SUB and 0 otherwise.
REQ-025 Non-MUL ops SHALL have 1-cycle latency: when valid_id=1 and state is IDLE, the next edge loads ans_ex, DM_data, flags and mem controls.
REQ-026 When valid_id=0, the next edge SHALL insert a bubble: mem_en_ex=0, mem_rw_ex=0, mem_mux_sel_dm=0, with ans_ex, DM_data and flag_ex holding.
REQ-027 The multiplier FSM SHALL have states IDLE, MUL and DONE, with a 3-bit iteration counter cnt.
REQ-028 In IDLE with valid_id=1 and op_ex=111, the next edge SHALL latch the forwarded operands, clear the accumulator, set cnt=0, go to MUL and emit a bubble.
REQ-029 In MUL, each edge SHALL perform one shift-add step, increment cnt and emit a bubble; at cnt=7 the next state SHALL be DONE.
REQ-030 In DONE, the next edge SHALL load the product into ans_ex together with flags, DM_data and mem controls from the held decode inputs, then return to IDLE.
REQ-031 stall SHALL equal (IDLE & valid_id & op_ex=111) | MUL, and SHALL be 0 in DONE and while reset=0.
REQ-032 A MUL accepted at edge n SHALL be stalled for 9 cycles and SHALL update ans_ex at edge n+9.
REQ-033 A MUL immediately following a MUL SHALL start from IDLE after DONE; there is no overlap.
REQ-034 Inputs SHALL be ignored while in the MUL state; operands are those latched at acceptance.

Reset
REQ-035 When reset=0 at an edge, ans_ex, DM_data, flag_ex, mem_rw_ex, mem_en_ex, mem_mux_sel_dm, the accumulator and cnt SHALL all become 0 and the state SHALL become IDLE.
REQ-036 A reset mid-MUL SHALL abort the multiply with no result written.
REQ-037 The first edge with reset=1 SHALL process inputs normally.

Verification
REQ-038 The bench SHALL check ADD A=8'h7F, B=8'h01 -> ans_ex=8'h80, flags Z0 C0 N1 V1, one edge later.
REQ-039 The bench SHALL check SUB A=8'h03, B=8'h05 -> ans_ex=8'hFE, C=1, N=1; SUB A=B=8'h03 -> Z=1.
REQ-040 The bench SHALL check forwarding: ADD result 8'h10, then ADD with fwd_a=01, B=8'h01 -> 8'h11; with fwd_b=10 and ans_dm=8'hFF -> DM_data=8'hFF.
REQ-041 The bench SHALL check MUL A=8'h0D, B=8'h0B: stall=1 for 9 cycles, mem_en_ex=0 during the stall, then ans_ex=8'h8F.
REQ-042 The bench SHALL check reset=0 at the 4th MUL cycle: all outputs 0 and stall=0; after release, ADD 1+1 -> 8'h02.
REQ-043 The bench SHALL check that valid_id=0 with mem_en_id=1 gives mem_en_ex=0 and ans_ex held.

Source files
------------

// File: rtl/ex_block.sv
// Execute stage: operand forwarding, single-cycle ALU and an iterative
// shift-add multiplier that stalls decode until its result is ready.
module ex_block (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [7:0] imm,
  input  logic       imm_sel,
  input  logic [2:0] op_ex,
  input  logic [1:0] fwd_a,
  input  logic [1:0] fwd_b,
  input  logic [7:0] ans_dm,
  input  logic       valid_id,
  input  logic       mem_rw_id,
  input  logic       mem_en_id,
  input  logic       mem_mux_sel_id,
  output logic [7:0] ans_ex,
  output logic [7:0] DM_data,
  output logic       mem_rw_ex,
  output logic       mem_en_ex,
  output logic       mem_mux_sel_dm,
  output logic [3:0] flag_ex,
  output logic       stall
);

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 3;
  localparam int unsigned FLW = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_DM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]  opa, fwd_b_val, opb;
  logic [DW-1:0]  alu_res;
  logic           alu_c, alu_v;
  logic [FLW-1:0] alu_flags;
  logic [DW:0]    sum9, shl9, shr9;
  logic [DW-1:0]  diff;

  logic [DW-1:0]  acc, mcand, mplier, sv_dm;
  logic [CW-1:0]  cnt;
  logic           sv_rw, sv_en, sv_mux;

  logic           is_mul;
  logic           alu_load, mul_start, mul_step, mul_load;

  // Operand selection; code 11 falls back to the register value
  always_comb begin
    case (fwd_a)
      FWD_EX:  opa = ans_ex;
      FWD_DM:  opa = ans_dm;
      default: opa = A;
    endcase
    case (fwd_b)
      FWD_EX:  fwd_b_val = ans_ex;
      FWD_DM:  fwd_b_val = ans_dm;
      default: fwd_b_val = B;
    endcase
    opb = imm_sel ? imm : fwd_b_val;
  end

  // Single-cycle ALU; shifts are widened by one bit to capture the bit shifted out
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum9    = {1'b0, opa} + {1'b0, opb};
    diff    = opa - opb;
    shl9    = {1'b0, opa} << opb[2:0];
    shr9    = {opa, 1'b0} >> opb[2:0];
    case (op_ex)
      OP_ADD: begin
        alu_res = sum9[DW-1:0];
        alu_c   = sum9[DW];
        alu_v   = (opa[DW-1] == opb[DW-1]) && (sum9[DW-1] != opa[DW-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = (opa < opb);
        alu_v   = (opa[DW-1] != opb[DW-1]) && (diff[DW-1] != opa[DW-1]);
      end
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      OP_XOR: alu_res = opa ^ opb;
      OP_SHL: begin
        alu_res = shl9[DW-1:0];
        alu_c   = shl9[DW];
      end
      OP_SHR: begin
        alu_res = shr9[DW:1];
        alu_c   = shr9[0];
      end
      default: alu_res = '0;
    endcase
    alu_flags = {(alu_res == '0), alu_c, alu_res[DW-1], alu_v};
  end

  assign is_mul = (op_ex == OP_MUL);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_id && is_mul) state_d = MUL;
      MUL:     if (cnt == CW'(7)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: datapath enables and the decode stall
  always_comb begin
    stall     = 1'b0;
    alu_load  = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    mul_load  = 1'b0;
    case (state_q)
      IDLE: begin
        stall     = valid_id && is_mul;
        mul_start = valid_id && is_mul;
        alu_load  = valid_id && !is_mul;
      end
      MUL: begin
        stall    = 1'b1;
        mul_step = 1'b1;
      end
      DONE:    mul_load = 1'b1;
      default: stall = 1'b0;
    endcase
    if (!reset) stall = 1'b0;
  end

  // Result registers and multiplier datapath; memory controls default to a bubble
  always_ff @(posedge clk) begin
    if (!reset) begin
      ans_ex         <= '0;
      DM_data        <= '0;
      flag_ex        <= '0;
      mem_rw_ex      <= 1'b0;
      mem_en_ex      <= 1'b0;
      mem_mux_sel_dm <= 1'b0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      cnt            <= '0;
      sv_dm          <= '0;
      sv_rw          <= 1'b0;
      sv_en          <= 1'b0;
      sv_mux         <= 1'b0;
    end else begin
      mem_rw_ex      <= 1'b0;
      mem_en_ex      <= 1'b0;
      mem_mux_sel_dm <= 1'b0;
      if (alu_load) begin
        ans_ex         <= alu_res;
        flag_ex        <= alu_flags;
        DM_data        <= fwd_b_val;
        mem_rw_ex      <= mem_rw_id;
        mem_en_ex      <= mem_en_id;
        mem_mux_sel_dm <= mem_mux_sel_id;
      end
      if (mul_start) begin
        mcand  <= opa;
        mplier <= opb;
        acc    <= '0;
        cnt    <= '0;
        sv_dm  <= fwd_b_val;
        sv_rw  <= mem_rw_id;
        sv_en  <= mem_en_id;
        sv_mux <= mem_mux_sel_id;
      end
      if (mul_step) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= {mcand[DW-2:0], 1'b0};
        mplier <= {1'b0, mplier[DW-1:1]};
        cnt    <= cnt + CW'(1);
      end
      if (mul_load) begin
        ans_ex         <= acc;
        flag_ex        <= {(acc == '0), 1'b0, acc[DW-1], 1'b0};
        DM_data        <= sv_dm;
        mem_rw_ex      <= sv_rw;
        mem_en_ex      <= sv_en;
        mem_mux_sel_dm <= sv_mux;
      end
    end
  end

endmodule

// File: tb/tb_ex_block.sv
// Scoreboard bench for ex_block: expected results are queued at issue and
// compared when the stage writes them back.
module tb_ex_block;

  logic       clk, reset;
  logic [7:0] A, B, imm, ans_dm;
  logic       imm_sel;
  logic [2:0] op_ex;
  logic [1:0] fwd_a, fwd_b;
  logic       valid_id, mem_rw_id, mem_en_id, mem_mux_sel_id;
  logic [7:0] ans_ex, DM_data;
  logic       mem_rw_ex, mem_en_ex, mem_mux_sel_dm;
  logic [3:0] flag_ex;
  logic       stall;

  typedef struct packed {
    logic [7:0] ans;
    logic [7:0] dmd;
    logic [3:0] fl;
    logic       rw;
    logic       en;
    logic       mux;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] model_ans, model_dm;
  logic [3:0] model_fl;

  ex_block dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .imm(imm), .imm_sel(imm_sel),
    .op_ex(op_ex), .fwd_a(fwd_a), .fwd_b(fwd_b), .ans_dm(ans_dm),
    .valid_id(valid_id), .mem_rw_id(mem_rw_id), .mem_en_id(mem_en_id),
    .mem_mux_sel_id(mem_mux_sel_id), .ans_ex(ans_ex), .DM_data(DM_data),
    .mem_rw_ex(mem_rw_ex), .mem_en_ex(mem_en_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
    .flag_ex(flag_ex), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference ALU returning {Z,C,N,V,result}, built on integer arithmetic
  function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, sa, sb, sr, r, s;
    logic [7:0] res;
    logic c, v;
    ia = int'(a);
    ib = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = int'(b[2:0]);
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    sr = 0;
    case (op)
      3'd0: begin r = ia + ib; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
      3'd1: begin r = ia - ib; c = (ia < ib); sr = sa - sb; v = (sr > 127) || (sr < -128); end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: begin r = ia << s; c = (s != 0) && (r[8] == 1'b1); end
      3'd6: begin r = ia >> s; c = (s != 0) ? (((ia >> (s - 1)) & 1) == 1) : 1'b0; end
      default: r = ia * ib;
    endcase
    res = r[7:0];
    return {(res == 8'd0), c, res[7], v, res};
  endfunction

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    check({tag, "_ans"}, ans_ex, e.ans);
    check({tag, "_dm"}, DM_data, e.dmd);
    check({tag, "_flags"}, flag_ex, e.fl);
    check({tag, "_memctl"}, {mem_rw_ex, mem_en_ex, mem_mux_sel_dm}, {e.rw, e.en, e.mux});
    model_ans = e.ans;
    model_dm  = e.dmd;
    model_fl  = e.fl;
  endtask

  // Issue one instruction, follow any multiply stall, then check the write-back
  task automatic send(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] im, input logic isel, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [7:0] dm_in, input logic rw, input logic en, input logic mux);
    logic [7:0]  o1, bf, o2;
    logic [11:0] m;
    exp_t        e;
    int          cyc;
    bf = (fb == 2'b01) ? model_ans : (fb == 2'b10) ? dm_in : b;
    o1 = (fa == 2'b01) ? model_ans : (fa == 2'b10) ? dm_in : a;
    o2 = isel ? im : bf;
    m  = model(op, o1, o2);
    e.ans = m[7:0];
    e.fl  = m[11:8];
    e.dmd = bf;
    e.rw  = rw;
    e.en  = en;
    e.mux = mux;
    sbq.push_back(e);
    @(negedge clk);
    A = a; B = b; imm = im; imm_sel = isel; op_ex = op; fwd_a = fa; fwd_b = fb;
    ans_dm = dm_in; mem_rw_id = rw; mem_en_id = en; mem_mux_sel_id = mux; valid_id = 1'b1;
    #1;
    if (op == 3'd7) begin
      cyc = 0;
      while (stall && cyc < 20) begin
        cyc++;
        if (cyc >= 2) check({tag, "_bubble_en"}, mem_en_ex, 1'b0);
        @(negedge clk);
        #1;
      end
      check({tag, "_stall_cycles"}, cyc, 9);
    end else begin
      check({tag, "_stall"}, stall, 1'b0);
    end
    @(posedge clk);
    #1;
    pop_compare(tag);
  endtask

  task automatic bubble(input string tag);
    @(negedge clk);
    valid_id = 1'b0; mem_en_id = 1'b1; mem_rw_id = 1'b1; mem_mux_sel_id = 1'b1; op_ex = 3'd0;
    @(posedge clk);
    #1;
    check({tag, "_memctl"}, {mem_rw_ex, mem_en_ex, mem_mux_sel_dm}, 3'b000);
    check({tag, "_ans_hold"}, ans_ex, model_ans);
    check({tag, "_dm_hold"}, DM_data, model_dm);
    check({tag, "_flags_hold"}, flag_ex, model_fl);
  endtask

  initial begin
    reset = 1'b0; A = '0; B = '0; imm = '0; imm_sel = 1'b0; fwd_a = '0; fwd_b = '0;
    ans_dm = '0; mem_rw_id = 1'b0; mem_en_id = 1'b0; mem_mux_sel_id = 1'b0;
    valid_id = 1'b1; op_ex = 3'd7;
    model_ans = '0; model_dm = '0; model_fl = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_ans", ans_ex, 8'h00);
    check("rst_dm", DM_data, 8'h00);
    check("rst_flags", flag_ex, 4'h0);
    check("rst_memctl", {mem_rw_ex, mem_en_ex, mem_mux_sel_dm}, 3'b000);
    valid_id = 1'b0; op_ex = 3'd0; reset = 1'b1;

    send("add_ovf", 3'd0, 8'h7F, 8'h01, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0);
    check("add_ovf_const", {flag_ex, ans_ex}, {4'b0011, 8'h80});
    send("sub_neg", 3'd1, 8'h03, 8'h05, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0);
    check("sub_neg_const", {flag_ex, ans_ex}, {4'b0110, 8'hFE});
    send("sub_zero", 3'd1, 8'h03, 8'h03, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("sub_zero_z", flag_ex[3], 1'b1);

    send("fwd_base", 3'd0, 8'h0F, 8'h01, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    send("fwd_a_ex", 3'd0, 8'hAA, 8'h01, 8'h00, 1'b0, 2'b01, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("fwd_a_ex_const", ans_ex, 8'h11);
    send("fwd_b_dm", 3'd0, 8'h01, 8'h55, 8'h00, 1'b0, 2'b00, 2'b10, 8'hFF, 1'b0, 1'b1, 1'b0);
    check("fwd_b_dm_const", DM_data, 8'hFF);
    send("fwd_imm", 3'd2, 8'hF0, 8'h33, 8'h3C, 1'b1, 2'b11, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0);
    send("or", 3'd3, 8'h81, 8'h18, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    send("xor", 3'd4, 8'hFF, 8'hFF, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    send("shl3", 3'd5, 8'hB1, 8'h00, 8'h03, 1'b1, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    send("shr1", 3'd6, 8'h03, 8'h01, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    send("shr0", 3'd6, 8'h9A, 8'h00, 8'h08, 1'b1, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("shr0_const", {flag_ex[2], ans_ex}, {1'b0, 8'h9A});

    send("mul", 3'd7, 8'h0D, 8'h0B, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0);
    check("mul_const", ans_ex, 8'h8F);
    send("mul_b2b", 3'd7, 8'h00, 8'h13, 8'h00, 1'b0, 2'b01, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1);
    send("mul_ovf", 3'd7, 8'hFF, 8'hFF, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      send("rand", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
      if (i % 5 == 0) bubble("rand_bub");
    end

    send("pre_abort", 3'd0, 8'h7F, 8'h01, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1);
    bubble("bubble");
    bubble("bubble2");

    @(negedge clk);
    A = 8'h0D; B = 8'h0B; imm_sel = 1'b0; fwd_a = '0; fwd_b = '0; op_ex = 3'd7;
    mem_en_id = 1'b1; valid_id = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_stall_lo", stall, 1'b0);
    @(posedge clk);
    #1;
    check("abort_ans", ans_ex, 8'h00);
    check("abort_dm", DM_data, 8'h00);
    check("abort_flags", flag_ex, 4'h0);
    check("abort_memctl", {mem_rw_ex, mem_en_ex, mem_mux_sel_dm}, 3'b000);
    check("abort_stall", stall, 1'b0);
    reset = 1'b1; valid_id = 1'b0; op_ex = 3'd0;
    model_ans = '0; model_dm = '0; model_fl = '0;
    sbq.delete();
    send("post_rst_add", 3'd0, 8'h01, 8'h01, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0);
    check("post_rst_const", ans_ex, 8'h02);
    repeat (10) bubble("post_abort");

    check("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
